// File: rtl/sha1_wb_master.sv
// Wishbone initiator that runs one SHA1 block through the SHA1 peripheral:
// clear engine, stream 16 words into MSG_IN, poll for DONE, read the digest, release.
module sha1_wb_master #(
  parameter logic [31:0] BASE_ADDRESS = 32'h30000024,
  parameter int          ACK_TIMEOUT  = 16,
  parameter int          POLL_MAX     = 1024
) (
  input  logic         wb_clk_i,
  input  logic         reset_n,
  input  logic         start,
  input  logic         msg_valid,
  output logic         msg_ready,
  input  logic [31:0]  msg_data,
  output logic         busy,
  output logic         digest_valid,
  output logic [159:0] digest,
  output logic         error,
  output logic [1:0]   err_code,
  output logic         wbm_cyc_o,
  output logic         wbm_stb_o,
  output logic         wbm_we_o,
  output logic [3:0]   wbm_sel_o,
  output logic [31:0]  wbm_adr_o,
  output logic [31:0]  wbm_dat_o,
  input  logic         wbm_ack_i,
  input  logic [31:0]  wbm_dat_i
);

  localparam logic [31:0] OPS_ADDR    = BASE_ADDRESS + 32'h8;
  localparam logic [31:0] MSG_ADDR    = BASE_ADDRESS + 32'hC;
  localparam logic [31:0] DIGEST_ADDR = BASE_ADDRESS + 32'h10;
  localparam int          PW          = $clog2(POLL_MAX + 1);
  localparam int          AW          = $clog2(ACK_TIMEOUT + 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX - 1);
  localparam logic [AW-1:0] ACK_LAST  = AW'(ACK_TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, CLEAR, LOAD, WRITE_MSG, POLL, READ_DIG, RELEASE, FINISH, ERROR
  } state_t;

  state_t         state, next_state;
  logic [3:0]     word_cnt;
  logic [2:0]     dig_cnt;
  logic [PW-1:0]  poll_cnt;
  logic [AW-1:0]  ack_timer;
  logic [31:0]    msg_word;
  logic           bus_done, ack_expired, accept_start;
  logic           bus_state, req_we;
  logic [31:0]    req_adr, req_dat;

  // Ack only counts while our strobe is up; a lingering ack after stb falls is ignored.
  assign bus_done     = wbm_stb_o & wbm_ack_i;
  assign ack_expired  = wbm_stb_o & ~wbm_ack_i & (ack_timer == ACK_LAST);
  assign accept_start = start & ((state == IDLE) | (state == ERROR));

  always_ff @(posedge wb_clk_i) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:      if (start) next_state = CLEAR;
      CLEAR:     if (ack_expired) next_state = ERROR;
                 else if (bus_done) next_state = LOAD;
      LOAD:      if (msg_valid) next_state = WRITE_MSG;
      WRITE_MSG: if (ack_expired) next_state = ERROR;
                 else if (bus_done) begin
                   if (wbm_dat_i != 32'h1)     next_state = ERROR;
                   else if (word_cnt == 4'd15) next_state = POLL;
                   else                        next_state = LOAD;
                 end
      POLL:      if (ack_expired) next_state = ERROR;
                 else if (bus_done) begin
                   if (wbm_dat_i[3])               next_state = READ_DIG;
                   else if (poll_cnt == POLL_LAST) next_state = ERROR;
                 end
      READ_DIG:  if (ack_expired) next_state = ERROR;
                 else if (bus_done && dig_cnt == 3'd4) next_state = RELEASE;
      RELEASE:   if (ack_expired) next_state = ERROR;
                 else if (bus_done) next_state = FINISH;
      FINISH:    next_state = IDLE;
      ERROR:     if (start) next_state = CLEAR;
      default:   next_state = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state != IDLE);
    msg_ready    = (state == LOAD);
    digest_valid = (state == FINISH);
    bus_state    = 1'b0;
    req_we       = 1'b0;
    req_adr      = 32'h0;
    req_dat      = 32'h0;
    unique case (state)
      CLEAR:     begin bus_state = 1'b1; req_we = 1'b1; req_adr = OPS_ADDR; req_dat = 32'h2; end
      WRITE_MSG: begin bus_state = 1'b1; req_we = 1'b1; req_adr = MSG_ADDR; req_dat = msg_word; end
      POLL:      begin bus_state = 1'b1; req_adr = OPS_ADDR; end
      READ_DIG:  begin bus_state = 1'b1; req_adr = DIGEST_ADDR; end
      RELEASE:   begin bus_state = 1'b1; req_we = 1'b1; req_adr = OPS_ADDR; end
      default:   ;
    endcase
  end

  // A bus state issues on its first (stb-low) cycle, which also provides the idle gap after each ack.
  always_ff @(posedge wb_clk_i) begin
    if (!reset_n) begin
      wbm_cyc_o <= 1'b0;  wbm_stb_o <= 1'b0;  wbm_we_o <= 1'b0;
      wbm_sel_o <= 4'h0;  wbm_adr_o <= 32'h0; wbm_dat_o <= 32'h0;
      digest    <= 160'h0;
      error     <= 1'b0;  err_code  <= 2'd0;
      word_cnt  <= 4'd0;  dig_cnt   <= 3'd0;
      poll_cnt  <= '0;    ack_timer <= '0;
      msg_word  <= 32'h0;
    end else begin
      if (accept_start) begin
        error    <= 1'b0;
        err_code <= 2'd0;
        word_cnt <= 4'd0;
        dig_cnt  <= 3'd0;
        poll_cnt <= '0;
      end
      if (state == LOAD && msg_valid) msg_word <= msg_data;

      if (bus_done || ack_expired) begin
        wbm_cyc_o <= 1'b0;  wbm_stb_o <= 1'b0;  wbm_we_o <= 1'b0;
        wbm_sel_o <= 4'h0;  wbm_adr_o <= 32'h0; wbm_dat_o <= 32'h0;
      end else if (bus_state && !wbm_stb_o) begin
        wbm_cyc_o <= 1'b1;  wbm_stb_o <= 1'b1;  wbm_we_o <= req_we;
        wbm_sel_o <= 4'hF;  wbm_adr_o <= req_adr; wbm_dat_o <= req_dat;
        ack_timer <= '0;
      end else if (wbm_stb_o) begin
        ack_timer <= ack_timer + AW'(1);
      end

      if (ack_expired) begin
        error    <= 1'b1;
        err_code <= 2'd1;
      end

      if (bus_done) begin
        unique case (state)
          WRITE_MSG: begin
            if (wbm_dat_i != 32'h1) begin
              error    <= 1'b1;
              err_code <= 2'd2;
            end else begin
              word_cnt <= word_cnt + 4'd1;
            end
          end
          POLL: begin
            if (!wbm_dat_i[3]) begin
              poll_cnt <= poll_cnt + PW'(1);
              if (poll_cnt == POLL_LAST) begin
                error    <= 1'b1;
                err_code <= 2'd3;
              end
            end
          end
          // Responder returns h4 first, so word k lands in digest slice k.
          READ_DIG: begin
            digest[32*dig_cnt +: 32] <= wbm_dat_i;
            dig_cnt <= dig_cnt + 3'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
